frog_collision: RTL

FROG_COLLISION -- requirements
Module: frog_collision

---
 rtl/frogger_pkg.sv | 21 ++
 rtl/freeze_timer.sv | 25 ++
 rtl/frog_collision.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/frogger_pkg.sv
// Shared types and defaults for the frogger collision/scoring slice.
// Holds the game FSM state encoding, grid geometry and parameter defaults.
package frogger_pkg;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        HIT  = 2'd1,
        OVER = 2'd2
    } frog_state_t;

    localparam int GRID           = 16;
    localparam int DEF_LIVES      = 3;
    localparam int DEF_HIT_CYCLES = 4;
    localparam int DEF_GOAL_ROW   = 0;

    // Score counter stops at its top value instead of wrapping to zero.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/freeze_timer.sv
// Down-counter that times the post-hit freeze.
// done is high during the final counted cycle, so the caller can leave HIT on that edge.
module freeze_timer (
    input  logic       clk,
    input  logic       RST,
    input  logic       load,
    input  logic [3:0] value,
    output logic       done
);

    logic [3:0] count_reg;

    always_ff @(posedge clk) begin
        if (RST) begin
            count_reg <= 4'd0;
        end else if (load) begin
            count_reg <= value;
        end else if (count_reg != 4'd0) begin
            count_reg <= count_reg - 4'd1;
        end
    end

    assign done = (count_reg == 4'd1);

endmodule

// File: rtl/frog_collision.sv
// Frog/car collision detector with lives, freeze-after-hit, goal scoring and respawn requests.
// Every output is a register; the inputs only feed next-state logic.
module frog_collision
    import frogger_pkg::*;
#(
    parameter int LIVES      = DEF_LIVES,
    parameter int HIT_CYCLES = DEF_HIT_CYCLES,
    parameter int GOAL_ROW   = DEF_GOAL_ROW
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [15:0][15:0] RedPixels,
    input  logic [3:0]        frog_row,
    input  logic [3:0]        frog_col,
    output logic              hit,
    output logic              respawn,
    output logic [1:0]        lives,
    output logic [3:0]        score,
    output logic              frozen,
    output logic              game_over
);

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [3:0] HIT_LEN    = 4'(HIT_CYCLES);
    localparam logic [3:0] GOAL_IDX   = 4'(GOAL_ROW);

    frog_state_t state_reg, state_next;
    logic [1:0]  lives_reg, lives_next;
    logic [3:0]  score_reg, score_next;
    logic        hit_reg, hit_next;
    logic        respawn_reg, respawn_next;
    logic        frozen_reg, frozen_next;
    logic        game_over_reg, game_over_next;
    logic        suppress_reg, suppress_next;
    logic        timer_load;
    logic        timer_done;

    // Flatten the grid row by row so {row, col} addresses one 256:1 mux.
    logic [GRID*GRID-1:0] pix_flat;
    logic                 car_at_frog;
    logic                 at_goal;

    genvar gi;
    generate
        for (gi = 0; gi < GRID; gi++) begin : g_flat
            assign pix_flat[gi*GRID +: GRID] = RedPixels[gi];
        end
    endgenerate

    assign car_at_frog = pix_flat[{frog_row, frog_col}];
    assign at_goal     = (frog_row == GOAL_IDX);

    freeze_timer u_freeze_timer (
        .clk   (clk),
        .RST   (RST),
        .load  (timer_load),
        .value (HIT_LEN),
        .done  (timer_done)
    );

    always_ff @(posedge clk) begin
        if (RST) begin
            state_reg     <= PLAY;
            lives_reg     <= LIVES_INIT;
            score_reg     <= 4'd0;
            hit_reg       <= 1'b0;
            respawn_reg   <= 1'b0;
            frozen_reg    <= 1'b0;
            game_over_reg <= 1'b0;
            suppress_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            lives_reg     <= lives_next;
            score_reg     <= score_next;
            hit_reg       <= hit_next;
            respawn_reg   <= respawn_next;
            frozen_reg    <= frozen_next;
            game_over_reg <= game_over_next;
            suppress_reg  <= suppress_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        lives_next    = lives_reg;
        score_next    = score_reg;
        hit_next      = 1'b0;
        respawn_next  = 1'b0;
        suppress_next = suppress_reg;
        timer_load    = 1'b0;

        // One sample off the goal row re-arms scoring after a respawn.
        if (!at_goal) begin
            suppress_next = 1'b0;
        end

        case (state_reg)
            PLAY: begin
                if (car_at_frog) begin
                    hit_next   = 1'b1;
                    lives_next = (lives_reg == 2'd0) ? 2'd0 : lives_reg - 2'd1;
                    if (lives_next != 2'd0) begin
                        state_next = HIT;
                        timer_load = 1'b1;
                    end else begin
                        state_next = OVER;
                    end
                end else if (at_goal && !suppress_reg) begin
                    score_next    = sat_inc4(score_reg);
                    respawn_next  = 1'b1;
                    suppress_next = 1'b1;
                end
            end
            HIT: begin
                if (timer_done) begin
                    state_next    = PLAY;
                    respawn_next  = 1'b1;
                    suppress_next = 1'b1;
                end
            end
            OVER: begin
                state_next = OVER;
            end
            default: begin
                state_next = PLAY;
            end
        endcase

        frozen_next    = (state_next != PLAY);
        game_over_next = (state_next == OVER);
    end

    assign hit       = hit_reg;
    assign respawn   = respawn_reg;
    assign lives     = lives_reg;
    assign score     = score_reg;
    assign frozen    = frozen_reg;
    assign game_over = game_over_reg;

endmodule
